// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle MIPS control unit and its datapath.
// The control unit takes opcode/zero in and drives every mux select and write enable.
interface unidade_controle_multiciclo_if;
   logic [5:0] opcode;
   logic       zero;
   logic       pc_en;
   logic       iord;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_src;
   logic       op_invalido;
   logic [3:0] estado;

   modport master (
      input  opcode, zero,
      output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
      output reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
      output op_invalido, estado
   );

   modport slave (
      output opcode, zero,
      input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
      input  reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
      input  op_invalido, estado
   );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath.
// Sequences FETCH/DECODE and the per-opcode execute states.
module unidade_controle_multiciclo (
   input  logic                            clock,
   input  logic                            reset,
   unidade_controle_multiciclo_if.master   bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   state_t state;
   state_t next;
   logic   pc_write;
   logic   branch;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= next;
   end

   always_comb begin
      next             = FETCH;
      pc_write         = 1'b0;
      branch           = 1'b0;
      bus.iord         = 1'b0;
      bus.mem_write    = 1'b0;
      bus.ir_write     = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.reg_write    = 1'b0;
      bus.alu_src_a    = 1'b0;
      bus.alu_src_b    = 2'b00;
      bus.alu_op       = 2'b00;
      bus.pc_src       = 2'b00;
      bus.op_invalido  = 1'b0;
      case (state)
         FETCH: begin
            next          = DECODE;
            bus.ir_write  = 1'b1;
            pc_write      = 1'b1;
            bus.alu_src_b = 2'b01;
         end
         DECODE: begin
            bus.alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: next = MEMADR;
               OP_RTYPE:     next = EXECUTE;
               OP_BEQ:       next = BRANCH;
               OP_ADDI:      next = ADDIEXEC;
               OP_J:         next = JUMP;
               default: begin
                  next            = FETCH;
                  bus.op_invalido = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            next = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            bus.iord = 1'b1;
            next     = MEMWB;
         end
         MEMWB: begin
            bus.mem_to_reg = 1'b1;
            bus.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            bus.iord      = 1'b1;
            bus.mem_write = 1'b1;
         end
         EXECUTE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
            next          = ALUWB;
         end
         ALUWB: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = 1'b1;
         end
         BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b01;
            bus.pc_src    = 2'b01;
            branch        = 1'b1;
         end
         ADDIEXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            next          = ADDIWB;
         end
         ADDIWB: bus.reg_write = 1'b1;
         JUMP: begin
            bus.pc_src = 2'b10;
            pc_write   = 1'b1;
         end
         default: next = FETCH;
      endcase
      // Reset blanks every output at once, even before the state register settles.
      if (reset) begin
         pc_write        = 1'b0;
         branch          = 1'b0;
         bus.iord        = 1'b0;
         bus.mem_write   = 1'b0;
         bus.ir_write    = 1'b0;
         bus.reg_dst     = 1'b0;
         bus.mem_to_reg  = 1'b0;
         bus.reg_write   = 1'b0;
         bus.alu_src_a   = 1'b0;
         bus.alu_src_b   = 2'b00;
         bus.alu_op      = 2'b00;
         bus.pc_src      = 2'b00;
         bus.op_invalido = 1'b0;
      end
      bus.pc_en  = pc_write | (branch & bus.zero);
      bus.estado = reset ? 4'd0 : state;
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multicycle control unit: per-instruction state paths and
// per-state output table checked every cycle, plus reset abort scenarios.
module tb_unidade_controle_multiciclo;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct {
      int         s;
      logic [5:0] op;
      logic       z;
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   exp_t q[$];

   unidade_controle_multiciclo_if bus ();

   unidade_controle_multiciclo dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, req, $time);
      end
   endtask

   function automatic logic supported(input logic [5:0] op);
      return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
             op == OP_BEQ || op == OP_ADDI || op == OP_J;
   endfunction

   // Expected state sequence of one instruction, FETCH included.
   function automatic void path_for(input logic [5:0] op, output int p[$]);
      p = {0, 1};
      if (op == OP_LW)         p = {p, 2, 3, 4};
      else if (op == OP_SW)    p = {p, 2, 5};
      else if (op == OP_RTYPE) p = {p, 6, 7};
      else if (op == OP_ADDI)  p = {p, 9, 10};
      else if (op == OP_BEQ)   p = {p, 8};
      else if (op == OP_J)     p = {p, 11};
   endfunction

   // {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
   //  alu_src_a,alu_src_b,alu_op,pc_src,op_invalido}
   function automatic logic [14:0] model(input int s, input logic [5:0] op,
                                         input logic z);
      logic pe, io, mw, iw, rd, m2r, rw, sa, inv;
      logic [1:0] sb, ao, ps;
      {pe, io, mw, iw, rd, m2r, rw, sa, inv} = '0;
      sb = 2'b00; ao = 2'b00; ps = 2'b00;
      if (s == 0) begin iw = 1; pe = 1; sb = 2'b01; end
      if (s == 1) begin sb = 2'b11; inv = !supported(op); end
      if (s == 2 || s == 9) begin sa = 1; sb = 2'b10; end
      if (s == 3) io = 1;
      if (s == 4) begin m2r = 1; rw = 1; end
      if (s == 5) begin io = 1; mw = 1; end
      if (s == 6) begin sa = 1; ao = 2'b10; end
      if (s == 7) begin rd = 1; rw = 1; end
      if (s == 10) rw = 1;
      if (s == 8) begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      if (s == 11) begin ps = 2'b10; pe = 1; end
      return {pe, io, mw, iw, rd, m2r, rw, sa, sb, ao, ps, inv};
   endfunction

   function automatic logic [14:0] actual();
      return {bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
              bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.pc_src, bus.op_invalido};
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         chk("reset_estado", 32'(bus.estado), 32'd0);
         chk("reset_outputs", 32'(actual()), 32'd0);
      end else if (q.size() > 0) begin
         e = q.pop_front();
         chk($sformatf("estado_s%0d", e.s), 32'(bus.estado), 32'(e.s));
         chk($sformatf("outputs_s%0d", e.s), 32'(actual()),
             32'(model(e.s, e.op, e.z)));
      end
   end

   // Called at posedge+1 while the DUT sits in FETCH.
   task automatic run_instr(input logic [5:0] op, input logic z,
                            input logic scramble);
      int   p[$];
      exp_t e;
      bus.opcode = op;
      bus.zero   = z;
      path_for(op, p);
      foreach (p[i]) begin
         e.s = p[i]; e.op = op; e.z = z;
         q.push_back(e);
      end
      repeat (2) @(posedge clock);
      #1;
      if (scramble) bus.opcode = ~op;
      repeat (p.size() - 2) @(posedge clock);
      #1;
   endtask

   initial begin
      exp_t e;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.opcode = OP_LW;
      bus.zero   = 1'b1;

      chk("pin_fetch", 32'(model(0, OP_LW, 1'b0)), 32'h4820);
      chk("pin_beq_taken", 32'(model(8, OP_BEQ, 1'b1)), 32'h408A);
      chk("pin_decode_bad", 32'(model(1, 6'h3f, 1'b0)), 32'h0061);
      chk("pin_memwb", 32'(model(4, OP_LW, 1'b0)), 32'h0300);

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      run_instr(OP_LW,    1'b0, 1'b0);
      run_instr(OP_RTYPE, 1'b1, 1'b1);
      run_instr(OP_BEQ,   1'b1, 1'b0);
      run_instr(OP_BEQ,   1'b0, 1'b0);
      run_instr(OP_SW,    1'b1, 1'b0);
      run_instr(OP_ADDI,  1'b1, 1'b1);
      run_instr(OP_J,     1'b0, 1'b0);
      run_instr(6'h3f,    1'b1, 1'b0);

      // Abort a load in MEMREAD.
      bus.opcode = OP_LW;
      bus.zero   = 1'b0;
      foreach (e.op[i]) begin end
      for (int i = 0; i < 3; i++) begin
         e.s = i; e.op = OP_LW; e.z = 1'b0;
         q.push_back(e);
      end
      repeat (3) @(posedge clock);
      #1;
      chk("abort_in_memread", 32'(bus.estado), 32'd3);
      chk("abort_iord", 32'(bus.iord), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_estado", 32'(bus.estado), 32'd0);
      chk("abort_outputs", 32'(actual()), 32'd0);
      @(posedge clock);
      #1;
      chk("abort_hold", 32'(bus.estado), 32'd0);
      reset = 1'b0;

      run_instr(OP_RTYPE, 1'b0, 1'b0);
      run_instr(6'h05,    1'b0, 1'b0);
      run_instr(OP_LW,    1'b1, 1'b1);

      @(negedge clock);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
